// File: rtl/alu_exec_unit.sv
// Integer/branch execution unit with a small result FIFO that broadcasts results on the CDB.
// Optional performance counters are enabled with the ALU_PERF_CNT_EN macro.
module alu_exec_unit #(
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                RS_input_valid,
    input  logic [5:0]          RS_OP_ID,
    input  logic [31:0]         RS_inst_pc,
    input  logic [31:0]         RS_reg_rs1,
    input  logic [31:0]         RS_reg_rs2,
    input  logic [31:0]         RS_imm,
    input  logic [ROB_ID_W-1:0] RS_ROB_id,
    output logic                ALU_is_full,
    output logic                CDB_valid,
    output logic [ROB_ID_W-1:0] CDB_ROB_id,
    output logic [31:0]         CDB_value,
    output logic                CDB_jump_flag,
    output logic [31:0]         CDB_target_pc,
    input  logic                CDB_grant,
    input  logic                ROB_roll_back_flag,
    output logic                ALU_overflow
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [31:0]         perf_issue_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ALERT = CNT_W'(FIFO_DEPTH - 1);

    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_SLTIU = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_ORI   = 6'd15;
    localparam logic [5:0] OP_ANDI  = 6'd16;
    localparam logic [5:0] OP_SLLI  = 6'd17;
    localparam logic [5:0] OP_SRLI  = 6'd18;
    localparam logic [5:0] OP_SRAI  = 6'd19;
    localparam logic [5:0] OP_ADD   = 6'd20;
    localparam logic [5:0] OP_SUB   = 6'd21;
    localparam logic [5:0] OP_SLL   = 6'd22;
    localparam logic [5:0] OP_SLT   = 6'd23;
    localparam logic [5:0] OP_SLTU  = 6'd24;
    localparam logic [5:0] OP_XOR   = 6'd25;
    localparam logic [5:0] OP_SRL   = 6'd26;
    localparam logic [5:0] OP_SRA   = 6'd27;
    localparam logic [5:0] OP_OR    = 6'd28;
    localparam logic [5:0] OP_AND   = 6'd29;

    logic [ROB_ID_W-1:0] rob_mem    [FIFO_DEPTH];
    logic [31:0]         value_mem  [FIFO_DEPTH];
    logic                jump_mem   [FIFO_DEPTH];
    logic [31:0]         target_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [31:0] res_value;
    logic        res_jump;
    logic [31:0] res_target;
    logic        br_taken;
    logic        is_branch;
    logic [4:0]  shamt_r;
    logic [4:0]  shamt_i;
    logic [31:0] br_target;
    logic [31:0] jalr_sum;

    logic push_req;
    logic push;
    logic pop;
    logic fifo_full;

    always_comb begin
        res_value  = '0;
        res_jump   = 1'b0;
        res_target = '0;
        br_taken   = 1'b0;
        is_branch  = 1'b0;
        shamt_r    = RS_reg_rs2[4:0];
        shamt_i    = RS_imm[4:0];
        br_target  = RS_inst_pc + RS_imm;
        jalr_sum   = RS_reg_rs1 + RS_imm;
        case (RS_OP_ID)
            OP_LUI:   res_value = RS_imm;
            OP_AUIPC: res_value = br_target;
            OP_JAL: begin
                res_value  = RS_inst_pc + 32'd4;
                res_jump   = 1'b1;
                res_target = br_target;
            end
            OP_JALR: begin
                res_value  = RS_inst_pc + 32'd4;
                res_jump   = 1'b1;
                res_target = {jalr_sum[31:1], 1'b0};
            end
            OP_BEQ:  begin is_branch = 1'b1; br_taken = (RS_reg_rs1 == RS_reg_rs2); end
            OP_BNE:  begin is_branch = 1'b1; br_taken = (RS_reg_rs1 != RS_reg_rs2); end
            OP_BLT:  begin is_branch = 1'b1; br_taken = ($signed(RS_reg_rs1) <  $signed(RS_reg_rs2)); end
            OP_BGE:  begin is_branch = 1'b1; br_taken = ($signed(RS_reg_rs1) >= $signed(RS_reg_rs2)); end
            OP_BLTU: begin is_branch = 1'b1; br_taken = (RS_reg_rs1 <  RS_reg_rs2); end
            OP_BGEU: begin is_branch = 1'b1; br_taken = (RS_reg_rs1 >= RS_reg_rs2); end
            OP_ADDI:  res_value = RS_reg_rs1 + RS_imm;
            OP_SLTI:  res_value = {31'd0, $signed(RS_reg_rs1) < $signed(RS_imm)};
            OP_SLTIU: res_value = {31'd0, RS_reg_rs1 < RS_imm};
            OP_XORI:  res_value = RS_reg_rs1 ^ RS_imm;
            OP_ORI:   res_value = RS_reg_rs1 | RS_imm;
            OP_ANDI:  res_value = RS_reg_rs1 & RS_imm;
            OP_SLLI:  res_value = RS_reg_rs1 << shamt_i;
            OP_SRLI:  res_value = RS_reg_rs1 >> shamt_i;
            OP_SRAI:  res_value = $unsigned($signed(RS_reg_rs1) >>> shamt_i);
            OP_ADD:   res_value = RS_reg_rs1 + RS_reg_rs2;
            OP_SUB:   res_value = RS_reg_rs1 - RS_reg_rs2;
            OP_SLL:   res_value = RS_reg_rs1 << shamt_r;
            OP_SLT:   res_value = {31'd0, $signed(RS_reg_rs1) < $signed(RS_reg_rs2)};
            OP_SLTU:  res_value = {31'd0, RS_reg_rs1 < RS_reg_rs2};
            OP_XOR:   res_value = RS_reg_rs1 ^ RS_reg_rs2;
            OP_SRL:   res_value = RS_reg_rs1 >> shamt_r;
            OP_SRA:   res_value = $unsigned($signed(RS_reg_rs1) >>> shamt_r);
            OP_OR:    res_value = RS_reg_rs1 | RS_reg_rs2;
            OP_AND:   res_value = RS_reg_rs1 & RS_reg_rs2;
            default:  res_value = '0;
        endcase
        if (is_branch) begin
            res_jump   = br_taken;
            res_target = br_taken ? br_target : 32'd0;
        end
    end

    // A full FIFO still accepts an issue when the head leaves in the same cycle.
    always_comb begin
        fifo_full = (count_q == CNT_FULL);
        pop       = rst && rdy && !ROB_roll_back_flag && (count_q != '0) && CDB_grant;
        push_req  = rst && rdy && !ROB_roll_back_flag && RS_input_valid;
        push      = push_req && (!fifo_full || pop);

        head_d     = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d     = push ? tail_q + PTR_W'(1) : tail_q;
        overflow_d = overflow_q | (push_req && fifo_full && !pop);
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (ROB_roll_back_flag) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rob_mem[tail_q]    <= RS_ROB_id;
            value_mem[tail_q]  <= res_value;
            jump_mem[tail_q]   <= res_jump;
            target_mem[tail_q] <= res_target;
        end
    end

    // Head fields are forced to zero while empty so stale entries never leak onto the bus.
    always_comb begin
        CDB_valid     = (count_q != '0);
        CDB_ROB_id    = CDB_valid ? rob_mem[head_q]    : '0;
        CDB_value     = CDB_valid ? value_mem[head_q]  : '0;
        CDB_jump_flag = CDB_valid ? jump_mem[head_q]   : 1'b0;
        CDB_target_pc = CDB_valid ? target_mem[head_q] : '0;
        ALU_is_full   = (count_q >= CNT_ALERT);
        ALU_overflow  = overflow_q;
    end

`ifdef ALU_PERF_CNT_EN
    logic [31:0] issue_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push) begin
                issue_cnt_q <= issue_cnt_q + 32'd1;
            end
            if (rdy && CDB_valid && !CDB_grant) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = issue_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios followed by random traffic
// compared against a queue-based reference model.
module tb_alu_exec_unit;

    localparam int DEPTH = 4;

    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_SLTIU = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_ORI   = 6'd15;
    localparam logic [5:0] OP_ANDI  = 6'd16;
    localparam logic [5:0] OP_SLLI  = 6'd17;
    localparam logic [5:0] OP_SRLI  = 6'd18;
    localparam logic [5:0] OP_SRAI  = 6'd19;
    localparam logic [5:0] OP_ADD   = 6'd20;
    localparam logic [5:0] OP_SUB   = 6'd21;
    localparam logic [5:0] OP_SLL   = 6'd22;
    localparam logic [5:0] OP_SLT   = 6'd23;
    localparam logic [5:0] OP_SLTU  = 6'd24;
    localparam logic [5:0] OP_XOR   = 6'd25;
    localparam logic [5:0] OP_SRL   = 6'd26;
    localparam logic [5:0] OP_SRA   = 6'd27;
    localparam logic [5:0] OP_OR    = 6'd28;
    localparam logic [5:0] OP_AND   = 6'd29;

    logic        clk = 1'b0;
    logic        rst, rdy, valid, grant, rb;
    logic [5:0]  op;
    logic [31:0] pc, rs1, rs2, imm;
    logic [3:0]  rob;

    logic        is_full, cdb_valid, cdb_jump, overflow;
    logic [3:0]  cdb_rob;
    logic [31:0] cdb_value, cdb_target;

    typedef struct {
        logic [3:0]  rob;
        logic [31:0] value;
        logic        jump;
        logic [31:0] target;
    } res_t;

    res_t model_q[$];
    logic model_ovf;
    int   tests = 0;
    int   fails = 0;

    alu_exec_unit #(.FIFO_DEPTH(DEPTH), .ROB_ID_W(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .RS_input_valid     (valid),
        .RS_OP_ID           (op),
        .RS_inst_pc         (pc),
        .RS_reg_rs1         (rs1),
        .RS_reg_rs2         (rs2),
        .RS_imm             (imm),
        .RS_ROB_id          (rob),
        .ALU_is_full        (is_full),
        .CDB_valid          (cdb_valid),
        .CDB_ROB_id         (cdb_rob),
        .CDB_value          (cdb_value),
        .CDB_jump_flag      (cdb_jump),
        .CDB_target_pc      (cdb_target),
        .CDB_grant          (grant),
        .ROB_roll_back_flag (rb),
        .ALU_overflow       (overflow)
    );

    always #5 clk = ~clk;

    function automatic res_t ref_exec(input logic [5:0] o, input logic [31:0] p, a, b, i,
                                      input logic [3:0] id);
        res_t r;
        int   sa, sb, si;
        logic taken;
        sa = a; sb = b; si = i;
        r.rob = id; r.value = 0; r.jump = 0; r.target = 0; taken = 0;
        case (o)
            OP_LUI:   r.value = i;
            OP_AUIPC: r.value = p + i;
            OP_JAL:   begin r.value = p + 4; r.jump = 1; r.target = p + i; end
            OP_JALR:  begin r.value = p + 4; r.jump = 1; r.target = (a + i) & 32'hFFFF_FFFE; end
            OP_BEQ:   taken = (a == b);
            OP_BNE:   taken = (a != b);
            OP_BLT:   taken = (sa < sb);
            OP_BGE:   taken = (sa >= sb);
            OP_BLTU:  taken = (a < b);
            OP_BGEU:  taken = (a >= b);
            OP_ADDI:  r.value = a + i;
            OP_SLTI:  r.value = (sa < si) ? 1 : 0;
            OP_SLTIU: r.value = (a < i) ? 1 : 0;
            OP_XORI:  r.value = a ^ i;
            OP_ORI:   r.value = a | i;
            OP_ANDI:  r.value = a & i;
            OP_SLLI:  r.value = a << (i % 32);
            OP_SRLI:  r.value = a >> (i % 32);
            OP_SRAI:  r.value = sa >>> (i % 32);
            OP_ADD:   r.value = a + b;
            OP_SUB:   r.value = a - b;
            OP_SLL:   r.value = a << (b % 32);
            OP_SLT:   r.value = (sa < sb) ? 1 : 0;
            OP_SLTU:  r.value = (a < b) ? 1 : 0;
            OP_XOR:   r.value = a ^ b;
            OP_SRL:   r.value = a >> (b % 32);
            OP_SRA:   r.value = sa >>> (b % 32);
            OP_OR:    r.value = a | b;
            OP_AND:   r.value = a & b;
            default:  r.value = 0;
        endcase
        if (o >= OP_BEQ && o <= OP_BGEU) begin
            r.jump   = taken;
            r.target = taken ? p + i : 0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance the model on the current inputs, clock the DUT, then compare every output.
    task automatic tick();
        int   n;
        logic do_pop;
        res_t h;
        if (!rst) begin
            model_q.delete();
            model_ovf = 0;
        end else if (rb) begin
            model_q.delete();
        end else if (rdy) begin
            n      = model_q.size();
            do_pop = (n > 0) && grant;
            if (do_pop) model_q.delete(0);
            if (valid) begin
                if (n == DEPTH && !do_pop) model_ovf = 1;
                else model_q.push_back(ref_exec(op, pc, rs1, rs2, imm, rob));
            end
        end
        @(posedge clk);
        #1;
        if (model_q.size() > 0) h = model_q[0];
        else begin h.rob = 0; h.value = 0; h.jump = 0; h.target = 0; end
        chk("cdb_valid",  {31'd0, cdb_valid}, {31'd0, model_q.size() > 0});
        chk("cdb_rob",    {28'd0, cdb_rob},   {28'd0, h.rob});
        chk("cdb_value",  cdb_value,          h.value);
        chk("cdb_jump",   {31'd0, cdb_jump},  {31'd0, h.jump});
        chk("cdb_target", cdb_target,         h.target);
        chk("is_full",    {31'd0, is_full},   {31'd0, model_q.size() >= DEPTH - 1});
        chk("overflow",   {31'd0, overflow},  {31'd0, model_ovf});
    endtask

    task automatic issue(input logic [5:0] o, input logic [31:0] p, a, b, i, input logic [3:0] id);
        valid = 1; op = o; pc = p; rs1 = a; rs2 = b; imm = i; rob = id;
    endtask

    initial begin
        rst = 0; rdy = 1; valid = 0; grant = 0; rb = 0;
        op = 0; pc = 0; rs1 = 0; rs2 = 0; imm = 0; rob = 0;
        model_ovf = 0;
        #2;
        tick();
        tick();
        rst = 1;

        // ADD 5+7 appears right after the issue edge and is gone the next cycle
        grant = 1;
        issue(OP_ADD, 0, 5, 7, 0, 3);
        tick();
        chk("add_value", cdb_value, 32'd12);
        chk("add_rob", {28'd0, cdb_rob}, 32'd3);
        valid = 0;
        tick();
        chk("add_gone", {31'd0, cdb_valid}, 32'd0);

        // signed vs unsigned branch compare
        issue(OP_BLT, 32'h100, 32'hFFFF_FFFF, 1, 32'h20, 5);
        tick();
        chk("blt_jump", {31'd0, cdb_jump}, 32'd1);
        chk("blt_target", cdb_target, 32'h120);
        issue(OP_BLTU, 32'h100, 32'hFFFF_FFFF, 1, 32'h20, 6);
        tick();
        chk("bltu_jump", {31'd0, cdb_jump}, 32'd0);
        chk("bltu_target", cdb_target, 32'd0);
        valid = 0;
        tick();

        issue(OP_JALR, 32'h200, 32'h1001, 0, 4, 7);
        tick();
        chk("jalr_value", cdb_value, 32'h204);
        chk("jalr_target", cdb_target, 32'h1004);
        valid = 0;
        tick();

        // fill without grant, then overflow, then drain in order
        grant = 0;
        for (int k = 0; k < 5; k++) begin
            issue(OP_ADDI, 0, 32'(k * 100), 0, 32'(k), 4'(k + 8));
            tick();
            if (k == 2) chk("full_at_3", {31'd0, is_full}, 32'd1);
        end
        chk("overflow_set", {31'd0, overflow}, 32'd1);
        valid = 0;
        grant = 1;
        for (int k = 0; k < 5; k++) tick();

        // roll back with two queued and a same-cycle issue
        grant = 0;
        issue(OP_LUI, 0, 0, 0, 32'hABC0_0000, 1); tick();
        issue(OP_LUI, 0, 0, 0, 32'hDEF0_0000, 2); tick();
        rb = 1;
        issue(OP_ADD, 0, 1, 1, 0, 4);
        tick();
        rb = 0; valid = 0;
        chk("rb_valid", {31'd0, cdb_valid}, 32'd0);
        chk("rb_full", {31'd0, is_full}, 32'd0);
        chk("rb_keeps_ovf", {31'd0, overflow}, 32'd1);

        // freeze with rdy low
        issue(OP_SUB, 0, 10, 3, 0, 9); tick();
        rdy = 0; grant = 1;
        issue(OP_ADD, 0, 2, 2, 0, 10);
        tick(); tick();
        rdy = 1; valid = 0;
        tick();

        // reset mid-drain with a full queue
        grant = 0;
        for (int k = 0; k < DEPTH; k++) begin
            issue(OP_XORI, 0, 32'h55, 0, 32'(k), 4'(k)); tick();
        end
        valid = 0; grant = 1;
        tick();
        rst = 0;
        tick();
        chk("rst_valid", {31'd0, cdb_valid}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1; grant = 0;
        issue(OP_JAL, 32'h40, 0, 0, 32'h10, 12);
        tick();
        valid = 0;
        tick();
        chk("post_rst_head", {28'd0, cdb_rob}, 32'd12);
        grant = 1;
        tick();
        chk("post_rst_sole", {31'd0, cdb_valid}, 32'd0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            valid = ($urandom_range(0, 3) != 0);
            op    = 6'($urandom_range(0, 31));
            pc    = $urandom;
            rs1   = $urandom;
            rs2   = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            imm   = $urandom;
            rob   = 4'($urandom);
            grant = ($urandom_range(0, 2) != 0);
            rdy   = ($urandom_range(0, 9) != 0);
            rb    = ($urandom_range(0, 39) == 0);
            rst   = ($urandom_range(0, 149) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
